// File: rtl/split_demux8_cache_pkg.sv
// Shared definitions for the 1-to-8 token split block on the cache control path.
// Holds channel geometry, the token layout and the destination-mask decode.
package split_demux8_cache_pkg;

    localparam int DEST_W       = 3;
    localparam int NUM_CH       = 8;
    localparam int TOKEN_DATA_W = 8;

    typedef struct packed {
        logic                    bcast;
        logic [DEST_W-1:0]       dest;
        logic [TOKEN_DATA_W-1:0] data;
    } token_t;

    // One-hot channel select for unicast, all channels for broadcast.
    function automatic logic [NUM_CH-1:0] dest_mask(input logic bcast, input logic [DEST_W-1:0] dest);
        logic [NUM_CH-1:0] mask_v;
        if (bcast) begin
            mask_v = {NUM_CH{1'b1}};
        end else begin
            mask_v = {{(NUM_CH-1){1'b0}}, 1'b1} << dest;
        end
        return mask_v;
    endfunction

endpackage

// File: rtl/split_chan_fifo.sv
// Per-channel output FIFO. Full is judged on the registered count only, so a
// pop in the same cycle never makes room for a push.
module split_chan_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_s;
    logic                  valid_s;
    logic                  push_s;
    logic                  pop_s;

    assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
    assign valid_s = (count_r != {CNT_W{1'b0}});
    assign push_s  = push & ~full_s;
    assign pop_s   = pop & valid_s;

    assign full  = full_s;
    assign valid = valid_s;
    assign head  = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/split_demux8_cache.sv
// 1-to-8 token split: routes each accepted token to one channel FIFO or, when
// broadcast, to all eight at once (all-or-nothing).
module split_demux8_cache
    import split_demux8_cache_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [2:0]                   i_dest,
    input  logic                         i_bcast,
    input  logic [DATA_WIDTH-1:0]        i_data,
    output logic [7:0]                   o_valid,
    input  logic [7:0]                   i_readyNext,
    output logic [8*DATA_WIDTH-1:0]      o_data,
    output logic [7:0]                   o_dropCnt
);
    logic [NUM_CH-1:0] full_s;
    logic [NUM_CH-1:0] valid_s;
    logic [NUM_CH-1:0] push_s;
    logic [NUM_CH-1:0] mask_s;
    logic              ready_s;
    logic              accept_s;
    logic              stall_s;
    logic [7:0]        drop_cnt_r;

    assign mask_s = dest_mask(i_bcast, i_dest);

    // Ready depends only on registered fullness and the current destination.
    always_comb begin
        ready_s = 1'b0;
        if (rst) begin
            ready_s = 1'b0;
        end else if (i_bcast) begin
            ready_s = ~|full_s;
        end else begin
            ready_s = ~full_s[i_dest];
        end
    end

    assign accept_s = i_valid & ready_s;
    assign stall_s  = i_valid & ~ready_s & ~rst;
    assign push_s   = {NUM_CH{accept_s}} & mask_s;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
            split_chan_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (push_s[k]),
                .pop   (i_readyNext[k]),
                .wdata (i_data),
                .full  (full_s[k]),
                .valid (valid_s[k]),
                .head  (o_data[k*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // Saturating count of stalled input cycles, for debug visibility.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 8'h00;
        end else if (stall_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'h01;
        end
    end

    assign o_ready   = ready_s;
    assign o_valid   = valid_s;
    assign o_dropCnt = drop_cnt_r;

endmodule

// File: tb/tb_split_demux8_cache.sv
// Directed self-checking bench for split_demux8_cache.
module tb_split_demux8_cache;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_dest;
    logic        i_bcast;
    logic [7:0]  i_data;
    logic [7:0]  o_valid;
    logic [7:0]  i_readyNext;
    logic [63:0] o_data;
    logic [7:0]  o_dropCnt;

    int n_tests;
    int n_fail;

    split_demux8_cache #(.DATA_WIDTH(8), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_dest      (i_dest),
        .i_bcast     (i_bcast),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_readyNext (i_readyNext),
        .o_data      (o_data),
        .o_dropCnt   (o_dropCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slice(input int k);
        return o_data[k*8 +: 8];
    endfunction

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_dest = 3'd0; i_bcast = 1'b0;
        i_data = 8'h00; i_readyNext = 8'h00;
        #1;
        n_tests++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %0b want 0", o_ready); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (o_valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid: got %h want 00", o_valid); end
        n_tests++;
        if (o_dropCnt !== 8'h00) begin n_fail++; $display("FAIL reset_dropcnt: got %h want 00", o_dropCnt); end
        n_tests++;
        if (o_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_data); end
        for (int d = 0; d < 8; d++) begin
            i_dest = 3'(d);
            #1;
            n_tests++;
            if (o_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready dest %0d: got %0b want 1", d, o_ready); end
        end
    endtask

    task automatic test_unicast();
        i_readyNext = 8'hFF;
        i_valid = 1'b1; i_dest = 3'd3; i_bcast = 1'b0; i_data = 8'hA5;
        #1;
        n_tests++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL uni_ready: got %0b want 1", o_ready); end
        tick();
        i_valid = 1'b0;
        #1;
        n_tests++;
        if (o_valid !== 8'h08) begin n_fail++; $display("FAIL uni_valid: got %h want 08", o_valid); end
        n_tests++;
        if (slice(3) !== 8'hA5) begin n_fail++; $display("FAIL uni_data: got %h want a5", slice(3)); end
        tick();
        n_tests++;
        if (o_valid !== 8'h00) begin n_fail++; $display("FAIL uni_drain: got %h want 00", o_valid); end
    endtask

    task automatic test_stall();
        i_readyNext = 8'hDF;
        i_valid = 1'b1; i_dest = 3'd5; i_data = 8'h11;
        tick();
        i_data = 8'h22;
        tick();
        i_data = 8'h33;
        #1;
        n_tests++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %0b want 0", o_ready); end
        n_tests++;
        if (slice(5) !== 8'h11) begin n_fail++; $display("FAIL stall_head: got %h want 11", slice(5)); end
        tick();
        n_tests++;
        if (o_dropCnt !== 8'h01) begin n_fail++; $display("FAIL stall_drop1: got %h want 01", o_dropCnt); end
        tick();
        n_tests++;
        if (o_dropCnt !== 8'h02) begin n_fail++; $display("FAIL stall_drop2: got %h want 02", o_dropCnt); end
        // Another channel still flows while channel 5 is stuck.
        i_dest = 3'd2; i_data = 8'h44;
        #1;
        n_tests++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL other_ready: got %0b want 1", o_ready); end
        tick();
        n_tests++;
        if (o_valid !== 8'h24) begin n_fail++; $display("FAIL other_valid: got %h want 24", o_valid); end
        n_tests++;
        if (slice(2) !== 8'h44) begin n_fail++; $display("FAIL other_data: got %h want 44", slice(2)); end
        // Release: space appears only after the registered count drops.
        i_dest = 3'd5; i_data = 8'h33; i_readyNext = 8'hFF;
        #1;
        n_tests++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL nofallthru: got %0b want 0", o_ready); end
        tick();
        n_tests++;
        if (slice(5) !== 8'h22) begin n_fail++; $display("FAIL order_2: got %h want 22", slice(5)); end
        n_tests++;
        if (o_dropCnt !== 8'h03) begin n_fail++; $display("FAIL stall_drop3: got %h want 03", o_dropCnt); end
        tick();
        i_valid = 1'b0;
        #1;
        n_tests++;
        if (slice(5) !== 8'h33 || o_valid[5] !== 1'b1) begin
            n_fail++; $display("FAIL order_3: got %h v=%0b want 33 v=1", slice(5), o_valid[5]);
        end
        tick();
        n_tests++;
        if (o_valid !== 8'h00) begin n_fail++; $display("FAIL stall_drain: got %h want 00", o_valid); end
    endtask

    task automatic test_bcast();
        i_readyNext = 8'hBF;
        i_valid = 1'b1; i_bcast = 1'b0; i_dest = 3'd6; i_data = 8'h61;
        tick();
        i_data = 8'h62;
        tick();
        i_bcast = 1'b1; i_dest = 3'd0; i_data = 8'h7E;
        #1;
        n_tests++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bc_blocked: got %0b want 0", o_ready); end
        tick();
        n_tests++;
        if (o_valid !== 8'h40) begin n_fail++; $display("FAIL bc_nowrite: got %h want 40", o_valid); end
        n_tests++;
        if (o_dropCnt !== 8'h04) begin n_fail++; $display("FAIL bc_drop: got %h want 04", o_dropCnt); end
        i_readyNext = 8'h40;
        tick();
        i_readyNext = 8'h00;
        #1;
        n_tests++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL bc_ready: got %0b want 1", o_ready); end
        tick();
        i_valid = 1'b0; i_bcast = 1'b0;
        #1;
        n_tests++;
        if (o_valid !== 8'hFF) begin n_fail++; $display("FAIL bc_valid: got %h want ff", o_valid); end
        for (int k = 0; k < 8; k++) begin
            if (k != 6) begin
                n_tests++;
                if (slice(k) !== 8'h7E) begin n_fail++; $display("FAIL bc_slice %0d: got %h want 7e", k, slice(k)); end
            end
        end
        n_tests++;
        if (slice(6) !== 8'h62) begin n_fail++; $display("FAIL bc_ch6_head: got %h want 62", slice(6)); end
        i_readyNext = 8'h40;
        tick();
        n_tests++;
        if (slice(6) !== 8'h7E) begin n_fail++; $display("FAIL bc_ch6_next: got %h want 7e", slice(6)); end
        i_readyNext = 8'hFF;
        tick();
        n_tests++;
        if (o_valid !== 8'h00) begin n_fail++; $display("FAIL bc_drain: got %h want 00", o_valid); end
    endtask

    task automatic test_back_to_back();
        i_readyNext = 8'h00;
        i_valid = 1'b1; i_bcast = 1'b0; i_dest = 3'd1; i_data = 8'h10;
        tick();
        for (int i = 0; i < 10; i++) begin
            i_data = 8'h20 + 8'(i);
            i_readyNext = 8'h02;
            #1;
            n_tests++;
            if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready %0d: got %0b want 1", i, o_ready); end
            tick();
            n_tests++;
            if (o_valid !== 8'h02 || slice(1) !== 8'h20 + 8'(i)) begin
                n_fail++; $display("FAIL b2b_head %0d: got v=%h d=%h want v=02 d=%h", i, o_valid, slice(1), 8'h20 + 8'(i));
            end
        end
        i_valid = 1'b0;
        tick();
        n_tests++;
        if (o_valid !== 8'h00) begin n_fail++; $display("FAIL b2b_drain: got %h want 00", o_valid); end
    endtask

    task automatic test_reset_mid();
        i_readyNext = 8'h00;
        i_valid = 1'b1; i_bcast = 1'b0; i_dest = 3'd0; i_data = 8'hC0;
        tick();
        i_dest = 3'd7; i_data = 8'hC7;
        tick();
        n_tests++;
        if (o_valid !== 8'h81) begin n_fail++; $display("FAIL mid_prefill: got %h want 81", o_valid); end
        rst = 1'b1; i_dest = 3'd0; i_data = 8'hDD;
        #1;
        n_tests++;
        if (o_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %0b want 0", o_ready); end
        tick();
        rst = 1'b0; i_valid = 1'b0;
        #1;
        n_tests++;
        if (o_valid !== 8'h00) begin n_fail++; $display("FAIL mid_valid: got %h want 00", o_valid); end
        n_tests++;
        if (o_dropCnt !== 8'h00) begin n_fail++; $display("FAIL mid_drop: got %h want 00", o_dropCnt); end
        tick();
        n_tests++;
        if (o_valid !== 8'h00) begin n_fail++; $display("FAIL mid_nostore: got %h want 00", o_valid); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_unicast();
        test_stall();
        test_bcast();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
